id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised, pipelined successor to the combinational decode stage. It decodes one MIPS instruction per cycle and forwards source operands from EX and MEM. It detects load-use hazards and inserts a bubble for them. Its result is held in a registered ID/EX boundary with valid/ready handshakes on both sides. It sits between IF and EX and drives the RegFile read ports.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/register width
- ADDR_WIDTH, 32, instruction address width
- REG_ADDR_WIDTH, 5, register index width
- FWD_EN, 1, 1 = EX/MEM forwarding enabled; 0 = operands taken from RegFile only

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  IF presents an instruction
- in_ready  out  1  ID accepts it this cycle
- in_addr  in  ADDR_WIDTH  instruction address
- in_inst  in  32  instruction word
- flush  in  1  discard the held and incoming instruction
- reg_read_en_1/2  out  1  RegFile read enables (combinational)
- reg_addr_1/2  out  REG_ADDR_WIDTH  RegFile read addresses (combinational)
- reg_data_1/2  in  DATA_WIDTH  RegFile read data, same cycle
- ex_fwd_en, ex_fwd_addr, ex_fwd_data  in  1/REG_ADDR_WIDTH/DATA_WIDTH  EX-stage ALU result
- mem_fwd_en, mem_fwd_addr, mem_fwd_data  in  1/REG_ADDR_WIDTH/DATA_WIDTH  MEM-stage result
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  EX consumes it this cycle
- out_addr, funct, operand_1, operand_2, shamt, write_reg_en, write_reg_addr, is_load  out  registered decode bundle

## Operation
- Decode:
  - SPECIAL: reads rs and rt; funct = inst funct; shamt = inst shamt; writes rd.
  - ORI, ANDI, XORI: read rs; operand_2 = zero-extended imm; funct = FUNCT_OR, FUNCT_AND, FUNCT_XOR; write rt.
  - ADDIU: as above, but operand_2 = sign-extended imm and funct = FUNCT_ADDU.
  - LUI: no reads; operand_2 = {imm, 16'b0}; funct = FUNCT_OR; operand_1 = 0; write rt.
  - LW: reads rs; operand_2 = sign-extended imm; funct = FUNCT_ADDU; is_load = 1; write rt.
  - Any other opcode: FUNCT_NOP, no reads, write_reg_en = 0. It still passes through as a valid instruction.
- Immediates are extended to DATA_WIDTH; shamt is 0 for every non-SPECIAL instruction.
- Operand source priority for each enabled read port:
  - index 0: value is always 0;
  - otherwise EX match, then MEM match, then RegFile.
  - A match requires *_fwd_en = 1 and an equal address. With FWD_EN = 0, the RegFile value is always used.
- Load-use hazard: out_valid && is_load && write_reg_en && write_reg_addr ≠ 0 && the address equals an enabled read address of the incoming instruction.
- Advance condition: adv = !out_valid || out_ready.
- in_ready = adv && !hazard && !flush.
- On an adv cycle, the ID/EX register loads as follows:
  - in_valid && in_ready: load the decoded bundle and set out_valid = 1.
  - Otherwise: out_valid = 0 (bubble); the other fields are don't-care but are set to their reset values.
- If !adv, the register holds unchanged, so its contents are stable under backpressure.
- flush has priority over everything: the next state is out_valid = 0, and the input is not accepted.

## Timing
- Read addresses, enables and forwarding muxes are combinational from in_inst.
- Decode-to-output latency is 1 cycle.
- A load-use hazard costs exactly one bubble cycle. In the following cycle the load has left the register, so the hazard clears and the consumer takes its operand from MEM forwarding.
- Reset, applied in any cycle including mid-stall: out_valid = 0, funct = FUNCT_NOP, operand_1/2 = 0, shamt = 0, write_reg_en = 0, write_reg_addr = 0, out_addr = 0, is_load = 0.
- While rst is high, reg_read_en_* = 0, reg_addr_* = 0 and in_ready = 0.
- Reset has priority over flush.
- When flush and a hazard occur together, flush wins and no bubble accounting is carried forward.

## Structure
- Add the new opcodes (ANDI, XORI, ADDIU, LUI, LW) to op_def.
- Add FUNCT_AND, FUNCT_XOR and FUNCT_ADDU to funct_def.
- Immediate extension helpers and the decode-bundle field widths go in a shared id_pkg.
- Split out one sub-module, operand_fwd_mux:
  - one instance per read port;
  - inputs: read enable and address, RegFile data, EX/MEM forwarding triplets, FWD_EN;
  - output: the selected operand.

## Test plan
- Reset is released, then ORI $1,$0,0x00FF: next cycle out_valid = 1, funct = FUNCT_OR, operand_2 = 0x000000FF, write_reg_addr = 1, shamt = 0.
- ex_fwd_addr = 3 with ex_fwd_data = 0xAAAA0000, mem_fwd_addr = 3 with mem_fwd_data = 0x1, RegFile $3 = 0x5, then SPECIAL OR $4,$3,$3: operand_1 = operand_2 = 0xAAAA0000. Repeating with FWD_EN = 0 gives 0x5.
- LW $2,4($1) followed by ADDIU $5,$2,-1: exactly one bubble cycle, then ADDIU issues with operand_2 = 0xFFFFFFFF and takes MEM-forwarded $2.
- out_ready is held low for 3 cycles with in_valid high: the output bundle is unchanged, in_ready = 0, and no instruction is lost or duplicated.
- flush asserted while LUI $7,0x1234 is held and ORI is incoming: next cycle out_valid = 0 and the ORI is not accepted.
- rst asserted during a load-use stall: outputs take their reset values on the next edge, and the first instruction after release decodes normally.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage.
// Opcodes, funct codes, bundle field widths and immediate helpers.
package id_pkg;

  localparam int INST_W  = 32;
  localparam int OP_W    = 6;
  localparam int FUNCT_W = 6;
  localparam int SHAMT_W = 5;
  localparam int IMM_W   = 16;
  localparam int FLD_W   = 5;

  // op_def
  localparam logic [OP_W-1:0] OP_SPECIAL = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDIU   = 6'b001001;
  localparam logic [OP_W-1:0] OP_ANDI    = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI     = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI    = 6'b001110;
  localparam logic [OP_W-1:0] OP_LUI     = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW      = 6'b100011;

  // funct_def
  localparam logic [FUNCT_W-1:0] FUNCT_NOP  = 6'b000000;
  localparam logic [FUNCT_W-1:0] FUNCT_ADDU = 6'b100001;
  localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_XOR  = 6'b100110;

  typedef enum logic [2:0] {
    OP2_NONE,
    OP2_RT,
    OP2_ZEXT,
    OP2_SEXT,
    OP2_LUI
  } op2_sel_e;

  function automatic logic [INST_W-1:0] zext_imm(
    input logic [IMM_W-1:0] imm
  );
    return {{(INST_W-IMM_W){1'b0}}, imm};
  endfunction

  function automatic logic [INST_W-1:0] sext_imm(
    input logic [IMM_W-1:0] imm
  );
    return {{(INST_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  function automatic logic [INST_W-1:0] lui_imm(
    input logic [IMM_W-1:0] imm
  );
    return {imm, {(INST_W-IMM_W){1'b0}}};
  endfunction

endpackage

// File: rtl/id_stage_pipe_operand_fwd_mux.sv
// Per-read-port operand source select.
// $0 reads zero, then EX, then MEM, then RegFile.
module operand_fwd_mux #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit FWD_EN         = 1'b1
) (
  input  logic                      rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]     rf_data,
  input  logic                      ex_en,
  input  logic [REG_ADDR_WIDTH-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0]     ex_data,
  input  logic                      mem_en,
  input  logic [REG_ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  output logic [DATA_WIDTH-1:0]     operand
);

  logic is_zero;
  logic ex_hit;
  logic mem_hit;

  assign is_zero = !rd_en || (rd_addr == '0);
  assign ex_hit  = FWD_EN && ex_en && (ex_addr == rd_addr);
  assign mem_hit = FWD_EN && mem_en && (mem_addr == rd_addr);

  // EX is the younger result, so it shadows MEM
  always_comb begin
    operand = rf_data;
    if (is_zero)
      operand = '0;
    else if (ex_hit)
      operand = ex_data;
    else if (mem_hit)
      operand = mem_data;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage with forwarding and a registered
// ID/EX boundary guarded by valid/ready on both sides.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit FWD_EN         = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [INST_W-1:0]         in_inst,
  input  logic                      flush,
  output logic                      reg_read_en_1,
  output logic                      reg_read_en_2,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr_1,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr_2,
  input  logic [DATA_WIDTH-1:0]     reg_data_1,
  input  logic [DATA_WIDTH-1:0]     reg_data_2,
  input  logic                      ex_fwd_en,
  input  logic [REG_ADDR_WIDTH-1:0] ex_fwd_addr,
  input  logic [DATA_WIDTH-1:0]     ex_fwd_data,
  input  logic                      mem_fwd_en,
  input  logic [REG_ADDR_WIDTH-1:0] mem_fwd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  output logic [FUNCT_W-1:0]        funct,
  output logic [DATA_WIDTH-1:0]     operand_1,
  output logic [DATA_WIDTH-1:0]     operand_2,
  output logic [SHAMT_W-1:0]        shamt,
  output logic                      write_reg_en,
  output logic [REG_ADDR_WIDTH-1:0] write_reg_addr,
  output logic                      is_load
);

  typedef struct packed {
    logic                      valid;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [FUNCT_W-1:0]        funct;
    logic [DATA_WIDTH-1:0]     op1;
    logic [DATA_WIDTH-1:0]     op2;
    logic [SHAMT_W-1:0]        shamt;
    logic                      wen;
    logic [REG_ADDR_WIDTH-1:0] waddr;
    logic                      is_load;
  } id_ex_t;

  localparam id_ex_t BUBBLE = '{
    valid:   1'b0,
    addr:    '0,
    funct:   FUNCT_NOP,
    op1:     '0,
    op2:     '0,
    shamt:   '0,
    wen:     1'b0,
    waddr:   '0,
    is_load: 1'b0
  };

  logic [OP_W-1:0]           op;
  logic [REG_ADDR_WIDTH-1:0] rs;
  logic [REG_ADDR_WIDTH-1:0] rt;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [SHAMT_W-1:0]        sa;
  logic [FUNCT_W-1:0]        fn;
  logic [IMM_W-1:0]          imm;

  assign op  = in_inst[31:26];
  assign rs  = REG_ADDR_WIDTH'(in_inst[25:21]);
  assign rt  = REG_ADDR_WIDTH'(in_inst[20:16]);
  assign rd  = REG_ADDR_WIDTH'(in_inst[15:11]);
  assign sa  = in_inst[10:6];
  assign fn  = in_inst[5:0];
  assign imm = in_inst[15:0];

  logic is_special;
  logic is_logic;
  logic is_addiu;
  logic is_lui;
  logic is_lw;

  assign is_special = op == OP_SPECIAL;
  assign is_logic   = (op == OP_ORI) || (op == OP_ANDI)
                   || (op == OP_XORI);
  assign is_addiu   = op == OP_ADDIU;
  assign is_lui     = op == OP_LUI;
  assign is_lw      = op == OP_LW;

  logic                      dec_re1;
  logic                      dec_re2;
  logic [FUNCT_W-1:0]        dec_funct;
  logic [SHAMT_W-1:0]        dec_shamt;
  logic                      dec_wen;
  logic [REG_ADDR_WIDTH-1:0] dec_waddr;
  logic                      dec_load;
  op2_sel_e                  dec_op2;

  // Opcode decode: read ports, ALU funct, destination
  always_comb begin
    dec_re1   = 1'b0;
    dec_re2   = 1'b0;
    dec_funct = FUNCT_NOP;
    dec_shamt = '0;
    dec_wen   = 1'b0;
    dec_waddr = '0;
    dec_load  = 1'b0;
    dec_op2   = OP2_NONE;
    unique case (1'b1)
      is_special: begin
        dec_re1   = 1'b1;
        dec_re2   = 1'b1;
        dec_funct = fn;
        dec_shamt = sa;
        dec_wen   = 1'b1;
        dec_waddr = rd;
        dec_op2   = OP2_RT;
      end
      is_logic: begin
        dec_re1   = 1'b1;
        dec_wen   = 1'b1;
        dec_waddr = rt;
        dec_op2   = OP2_ZEXT;
        unique case (1'b1)
          op == OP_ANDI: dec_funct = FUNCT_AND;
          op == OP_XORI: dec_funct = FUNCT_XOR;
          default:       dec_funct = FUNCT_OR;
        endcase
      end
      is_addiu: begin
        dec_re1   = 1'b1;
        dec_funct = FUNCT_ADDU;
        dec_wen   = 1'b1;
        dec_waddr = rt;
        dec_op2   = OP2_SEXT;
      end
      is_lui: begin
        dec_funct = FUNCT_OR;
        dec_wen   = 1'b1;
        dec_waddr = rt;
        dec_op2   = OP2_LUI;
      end
      is_lw: begin
        dec_re1   = 1'b1;
        dec_funct = FUNCT_ADDU;
        dec_wen   = 1'b1;
        dec_waddr = rt;
        dec_load  = 1'b1;
        dec_op2   = OP2_SEXT;
      end
      default: begin
      end
    endcase
  end

  assign reg_read_en_1 = !rst && dec_re1;
  assign reg_read_en_2 = !rst && dec_re2;
  assign reg_addr_1    = reg_read_en_1 ? rs : '0;
  assign reg_addr_2    = reg_read_en_2 ? rt : '0;

  logic [DATA_WIDTH-1:0] fwd_1;
  logic [DATA_WIDTH-1:0] fwd_2;

  operand_fwd_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .FWD_EN         (FWD_EN)
  ) u_fwd_1 (
    .rd_en    (reg_read_en_1),
    .rd_addr  (reg_addr_1),
    .rf_data  (reg_data_1),
    .ex_en    (ex_fwd_en),
    .ex_addr  (ex_fwd_addr),
    .ex_data  (ex_fwd_data),
    .mem_en   (mem_fwd_en),
    .mem_addr (mem_fwd_addr),
    .mem_data (mem_fwd_data),
    .operand  (fwd_1)
  );

  operand_fwd_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .FWD_EN         (FWD_EN)
  ) u_fwd_2 (
    .rd_en    (reg_read_en_2),
    .rd_addr  (reg_addr_2),
    .rf_data  (reg_data_2),
    .ex_en    (ex_fwd_en),
    .ex_addr  (ex_fwd_addr),
    .ex_data  (ex_fwd_data),
    .mem_en   (mem_fwd_en),
    .mem_addr (mem_fwd_addr),
    .mem_data (mem_fwd_data),
    .operand  (fwd_2)
  );

  logic [DATA_WIDTH-1:0] imm_z;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] op2_val;

  assign imm_z = DATA_WIDTH'(zext_imm(imm));
  assign imm_s = DATA_WIDTH'($signed(sext_imm(imm)));
  assign imm_u = DATA_WIDTH'(lui_imm(imm));

  // Second operand: register, or one of the immediate forms
  always_comb begin
    op2_val = '0;
    unique case (dec_op2)
      OP2_RT:   op2_val = fwd_2;
      OP2_ZEXT: op2_val = imm_z;
      OP2_SEXT: op2_val = imm_s;
      OP2_LUI:  op2_val = imm_u;
      default:  op2_val = '0;
    endcase
  end

  id_ex_t d;
  id_ex_t q;

  assign d = '{
    valid:   1'b1,
    addr:    in_addr,
    funct:   dec_funct,
    op1:     fwd_1,
    op2:     op2_val,
    shamt:   dec_shamt,
    wen:     dec_wen,
    waddr:   dec_waddr,
    is_load: dec_load
  };

  logic ld_hit_1;
  logic ld_hit_2;
  logic hazard;
  logic adv;
  logic accept;

  // A load still in ID/EX cannot feed a reader yet
  assign ld_hit_1 = reg_read_en_1 && (reg_addr_1 == q.waddr);
  assign ld_hit_2 = reg_read_en_2 && (reg_addr_2 == q.waddr);
  assign hazard   = q.valid && q.is_load && q.wen
                 && (q.waddr != '0) && (ld_hit_1 || ld_hit_2);
  assign adv      = !q.valid || out_ready;
  assign in_ready = !rst && adv && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // ID/EX boundary: load on advance, hold under backpressure
  always_ff @(posedge clk) begin
    if (rst)
      q <= BUBBLE;
    else if (flush)
      q <= BUBBLE;
    else if (adv)
      q <= accept ? d : BUBBLE;
  end

  assign out_valid      = q.valid;
  assign out_addr       = q.addr;
  assign funct          = q.funct;
  assign operand_1      = q.op1;
  assign operand_2      = q.op2;
  assign shamt          = q.shamt;
  assign write_reg_en   = q.wen;
  assign write_reg_addr = q.waddr;
  assign is_load        = q.is_load;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed table, then random
// traffic against a behavioural model of the stage.
module tb_id_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_addr, in_inst;
  logic        ex_fwd_en, mem_fwd_en;
  logic [4:0]  ex_fwd_addr, mem_fwd_addr;
  logic [31:0] ex_fwd_data, mem_fwd_data;

  logic        in_ready, reg_read_en_1, reg_read_en_2;
  logic [4:0]  reg_addr_1, reg_addr_2;
  logic [31:0] reg_data_1, reg_data_2;
  logic        out_valid, write_reg_en, is_load;
  logic [31:0] out_addr, operand_1, operand_2;
  logic [5:0]  funct;
  logic [4:0]  shamt, write_reg_addr;

  logic        nf_in_ready, nf_re_1, nf_re_2;
  logic [4:0]  nf_ra_1, nf_ra_2;
  logic [31:0] nf_rd_1, nf_rd_2;
  logic        nf_out_valid, nf_wen, nf_is_load;
  logic [31:0] nf_out_addr, nf_operand_1, nf_operand_2;
  logic [5:0]  nf_funct;
  logic [4:0]  nf_shamt, nf_waddr;

  logic [31:0] rf [32];

  assign reg_data_1 = rf[reg_addr_1];
  assign reg_data_2 = rf[reg_addr_2];
  assign nf_rd_1    = rf[nf_ra_1];
  assign nf_rd_2    = rf[nf_ra_2];

  id_stage_pipe #(.FWD_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_inst(in_inst), .flush(flush),
    .reg_read_en_1(reg_read_en_1), .reg_read_en_2(reg_read_en_2),
    .reg_addr_1(reg_addr_1), .reg_addr_2(reg_addr_2),
    .reg_data_1(reg_data_1), .reg_data_2(reg_data_2),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr),
    .ex_fwd_data(ex_fwd_data),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr),
    .mem_fwd_data(mem_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .funct(funct),
    .operand_1(operand_1), .operand_2(operand_2),
    .shamt(shamt), .write_reg_en(write_reg_en),
    .write_reg_addr(write_reg_addr), .is_load(is_load)
  );

  id_stage_pipe #(.FWD_EN(1'b0)) u_nf (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(nf_in_ready),
    .in_addr(in_addr), .in_inst(in_inst), .flush(flush),
    .reg_read_en_1(nf_re_1), .reg_read_en_2(nf_re_2),
    .reg_addr_1(nf_ra_1), .reg_addr_2(nf_ra_2),
    .reg_data_1(nf_rd_1), .reg_data_2(nf_rd_2),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr),
    .ex_fwd_data(ex_fwd_data),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr),
    .mem_fwd_data(mem_fwd_data),
    .out_valid(nf_out_valid), .out_ready(out_ready),
    .out_addr(nf_out_addr), .funct(nf_funct),
    .operand_1(nf_operand_1), .operand_2(nf_operand_2),
    .shamt(nf_shamt), .write_reg_en(nf_wen),
    .write_reg_addr(nf_waddr), .is_load(nf_is_load)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] addr;
    logic [5:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  shamt;
    logic        wen;
    logic [4:0]  waddr;
    logic        ld;
    logic [31:0] nf1;
    logic [31:0] nf2;
  } st_t;

  typedef struct {
    bit          rst, iv, fl, ordy;
    logic [31:0] inst;
    bit          exe;
    logic [4:0]  exa;
    logic [31:0] exd;
    bit          meme;
    logic [4:0]  mema;
    logic [31:0] memd;
    bit          rdy;
    bit          v;
    logic [5:0]  fn;
    logic [31:0] o1, o2;
    logic [4:0]  sh, wa;
    bit          ld;
    logic [31:0] n1, n2;
  } row_t;

  st_t m, mn;
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] src(input logic [4:0] a,
                                      input bit fwd);
    if (a == 5'd0) return 32'h0;
    if (fwd && ex_fwd_en && ex_fwd_addr == a) return ex_fwd_data;
    if (fwd && mem_fwd_en && mem_fwd_addr == a) return mem_fwd_data;
    return rf[a];
  endfunction

  function automatic logic [63:0] ops(input logic [31:0] inst,
                                      input bit fwd);
    logic [15:0] imm;
    logic [31:0] a, b;
    imm = inst[15:0];
    a = src(inst[25:21], fwd);
    b = src(inst[20:16], fwd);
    case (inst[31:26])
      6'h00:               return {a, b};
      6'h0C, 6'h0D, 6'h0E: return {a, 16'h0, imm};
      6'h09, 6'h23:        return {a, {16{imm[15]}}, imm};
      6'h0F:               return {32'h0, imm, 16'h0};
      default:             return 64'h0;
    endcase
  endfunction

  function automatic st_t model_decode(input logic [31:0] inst,
                                       input logic [31:0] a);
    st_t s;
    logic [63:0] f, n;
    s = '0;
    f = ops(inst, 1'b1);
    n = ops(inst, 1'b0);
    s.v = 1'b1;
    s.addr = a;
    {s.op1, s.op2} = f;
    {s.nf1, s.nf2} = n;
    case (inst[31:26])
      6'h00: begin
        s.funct = inst[5:0]; s.shamt = inst[10:6];
        s.wen = 1'b1; s.waddr = inst[15:11];
      end
      6'h0D, 6'h0F: begin
        s.funct = 6'h25; s.wen = 1'b1; s.waddr = inst[20:16];
      end
      6'h0C: begin
        s.funct = 6'h24; s.wen = 1'b1; s.waddr = inst[20:16];
      end
      6'h0E: begin
        s.funct = 6'h26; s.wen = 1'b1; s.waddr = inst[20:16];
      end
      6'h09: begin
        s.funct = 6'h21; s.wen = 1'b1; s.waddr = inst[20:16];
      end
      6'h23: begin
        s.funct = 6'h21; s.wen = 1'b1; s.waddr = inst[20:16];
        s.ld = 1'b1;
      end
      default: s.funct = 6'h00;
    endcase
    return s;
  endfunction

  // {re1, ra1, re2, ra2}
  function automatic logic [11:0] rd_ports(input logic [31:0] inst);
    case (inst[31:26])
      6'h00:
        return {1'b1, inst[25:21], 1'b1, inst[20:16]};
      6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h23:
        return {1'b1, inst[25:21], 6'b0};
      default:
        return 12'h0;
    endcase
  endfunction

  bit m_rdy;

  task automatic cycle_begin();
    logic [11:0] p;
    bit haz, adv;
    @(negedge clk);
    p = rst ? 12'h0 : rd_ports(in_inst);
    chk("rd_ports",
        128'({reg_read_en_1, reg_addr_1, reg_read_en_2, reg_addr_2,
              nf_re_1, nf_ra_1, nf_re_2, nf_ra_2}),
        128'({p, p}));
    haz = m.v && m.ld && m.wen && m.waddr != 5'd0 &&
          ((p[11] && p[10:6] == m.waddr) ||
           (p[5] && p[4:0] == m.waddr));
    adv = !m.v || out_ready;
    m_rdy = !rst && adv && !haz && !flush;
    chk("in_ready", 128'({nf_in_ready, in_ready}),
        128'({m_rdy, m_rdy}));
    if (rst || flush) mn = '0;
    else if (!adv) mn = m;
    else if (in_valid && m_rdy) mn = model_decode(in_inst, in_addr);
    else mn = '0;
  endtask

  task automatic cycle_end();
    @(posedge clk);
    #1;
    m = mn;
    cyc++;
    chk("bundle",
        128'({out_valid, out_addr, funct, operand_1, operand_2,
              shamt, write_reg_en, write_reg_addr, is_load}),
        128'({m.v, m.addr, m.funct, m.op1, m.op2,
              m.shamt, m.wen, m.waddr, m.ld}));
    chk("nf_ops",
        128'({nf_out_valid, nf_operand_1, nf_operand_2}),
        128'({m.v, m.nf1, m.nf2}));
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sa;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    sa = 5'($urandom);
    case ($urandom_range(0, 7))
      0: op = 6'h00;
      1: op = 6'h0D;
      2: op = 6'h0C;
      3: op = 6'h0E;
      4: op = 6'h09;
      5: op = 6'h0F;
      6: op = 6'h23;
      default: op = 6'h02;
    endcase
    case ($urandom_range(0, 3))
      0: fn = 6'h25;
      1: fn = 6'h21;
      2: fn = 6'h26;
      default: fn = 6'h00;
    endcase
    if (op == 6'h00) return {op, rs, rt, rd, sa, fn};
    return {op, rs, rt, 16'($urandom)};
  endfunction

  localparam logic [31:0] I_ORI1  = 32'h340100FF;
  localparam logic [31:0] I_OR4   = 32'h00632025;
  localparam logic [31:0] I_LW2   = 32'h8C220004;
  localparam logic [31:0] I_ADDIU = 32'h2445FFFF;
  localparam logic [31:0] I_LUI7  = 32'h3C071234;
  localparam logic [31:0] I_ORI8  = 32'h34280005;
  localparam logic [31:0] I_J     = 32'h08000000;

  row_t tbl[22];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'hDEADBEEF;
    rf[3] = 32'h5;

    tbl[0]  = '{1,1,0,1, I_ORI1,  0,0,0, 0,0,0, 0,
                0,6'h00,0,0,0,0,0,0,0};
    tbl[1]  = '{0,1,0,1, I_ORI1,  0,0,0, 0,0,0, 1,
                1,6'h25,0,32'hFF,0,1,0,0,32'hFF};
    tbl[2]  = '{0,1,0,1, I_OR4,   1,3,32'hAAAA0000, 1,3,1, 1,
                1,6'h25,32'hAAAA0000,32'hAAAA0000,0,4,0,5,5};
    tbl[3]  = '{0,1,0,1, I_LW2,   0,0,0, 0,0,0, 1,
                1,6'h21,32'h101,4,0,2,1,32'h101,4};
    tbl[4]  = '{0,1,0,1, I_ADDIU, 0,0,0, 0,0,0, 0,
                0,6'h00,0,0,0,0,0,0,0};
    tbl[5]  = '{0,1,0,1, I_ADDIU, 0,0,0, 1,2,32'h12345678, 1,
                1,6'h21,32'h12345678,32'hFFFFFFFF,0,5,0,
                32'h102,32'hFFFFFFFF};
    tbl[6]  = '{0,1,0,1, I_LUI7,  0,0,0, 0,0,0, 1,
                1,6'h25,0,32'h12340000,0,7,0,0,32'h12340000};
    for (int i = 7; i < 10; i++)
      tbl[i] = '{0,1,0,0, I_ORI8, 0,0,0, 0,0,0, 0,
                 1,6'h25,0,32'h12340000,0,7,0,0,32'h12340000};
    tbl[10] = '{0,1,0,1, I_ORI8,  0,0,0, 0,0,0, 1,
                1,6'h25,32'h101,5,0,8,0,32'h101,5};
    tbl[11] = '{0,1,0,1, I_LUI7,  0,0,0, 0,0,0, 1,
                1,6'h25,0,32'h12340000,0,7,0,0,32'h12340000};
    tbl[12] = '{0,1,1,0, I_ORI8,  0,0,0, 0,0,0, 0,
                0,6'h00,0,0,0,0,0,0,0};
    tbl[13] = '{0,0,0,1, I_ORI8,  0,0,0, 0,0,0, 1,
                0,6'h00,0,0,0,0,0,0,0};
    tbl[14] = '{0,1,0,1, I_LW2,   0,0,0, 0,0,0, 1,
                1,6'h21,32'h101,4,0,2,1,32'h101,4};
    tbl[15] = '{1,1,0,1, I_ADDIU, 0,0,0, 0,0,0, 0,
                0,6'h00,0,0,0,0,0,0,0};
    tbl[16] = '{0,1,0,1, I_ADDIU, 0,0,0, 0,0,0, 1,
                1,6'h21,32'h102,32'hFFFFFFFF,0,5,0,
                32'h102,32'hFFFFFFFF};
    tbl[17] = '{0,1,0,1, I_J,     0,0,0, 0,0,0, 1,
                1,6'h00,0,0,0,0,0,0,0};
    tbl[18] = '{0,0,0,1, I_J,     0,0,0, 0,0,0, 1,
                0,6'h00,0,0,0,0,0,0,0};
    tbl[19] = '{0,1,0,1, I_LW2,   0,0,0, 0,0,0, 1,
                1,6'h21,32'h101,4,0,2,1,32'h101,4};
    tbl[20] = '{0,1,1,1, I_ADDIU, 0,0,0, 0,0,0, 0,
                0,6'h00,0,0,0,0,0,0,0};
    tbl[21] = '{0,1,0,1, I_ADDIU, 0,0,0, 0,0,0, 1,
                1,6'h21,32'h102,32'hFFFFFFFF,0,5,0,
                32'h102,32'hFFFFFFFF};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_addr = '0; in_inst = '0;
    ex_fwd_en = 1'b0; ex_fwd_addr = '0; ex_fwd_data = '0;
    mem_fwd_en = 1'b0; mem_fwd_addr = '0; mem_fwd_data = '0;
    m = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      rst = tbl[i].rst; in_valid = tbl[i].iv;
      flush = tbl[i].fl; out_ready = tbl[i].ordy;
      in_inst = tbl[i].inst; in_addr = 32'h400 + 32'(4 * i);
      ex_fwd_en = tbl[i].exe; ex_fwd_addr = tbl[i].exa;
      ex_fwd_data = tbl[i].exd;
      mem_fwd_en = tbl[i].meme; mem_fwd_addr = tbl[i].mema;
      mem_fwd_data = tbl[i].memd;
      cycle_begin();
      chk($sformatf("t%0d_rdy", i), 128'(in_ready),
          128'(tbl[i].rdy));
      cycle_end();
      chk($sformatf("t%0d_out", i),
          128'({out_valid, funct, operand_1, operand_2,
                shamt, write_reg_addr, is_load}),
          128'({tbl[i].v, tbl[i].fn, tbl[i].o1, tbl[i].o2,
                tbl[i].sh, tbl[i].wa, tbl[i].ld}));
      chk($sformatf("t%0d_nf", i),
          128'({nf_operand_1, nf_operand_2}),
          128'({tbl[i].n1, tbl[i].n2}));
    end

    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_inst = rnd_inst();
      in_addr = $urandom;
      ex_fwd_en = 1'($urandom_range(0, 1));
      ex_fwd_addr = 5'($urandom_range(0, 7));
      ex_fwd_data = $urandom;
      mem_fwd_en = 1'($urandom_range(0, 1));
      mem_fwd_addr = 5'($urandom_range(0, 7));
      mem_fwd_data = $urandom;
      cycle_begin();
      cycle_end();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
